alu_iter: RTL and testbench

Parametrised execute-stage ALU for the pipelined MIPS datapath. It extends the base AND/OR/ADD/SUB/SLT/NOR operation set with XOR, shifts, unsigned compare and signed overflow detection. It also adds iterative multiply/divide writing HI/LO registers. Single-cycle operations are registered and accepted every cycle. Multiply/divide occupy the unit for WIDTH cycles, and a valid/ready handshake stalls the pipeline during that time.

---
 rtl/alu_iter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_alu_iter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: registered execute-stage ALU; `define ALU_MULDIV_EN adds iterative MULT/DIV into HI/LO.
// Single ops finish one cycle after acceptance at full rate; mul/div drop in_ready for WIDTH cycles; out_valid is never stalled.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
`endif

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] add_res;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;

  assign shamt   = B[SW-1:0];
  assign add_res = A + B;
  assign sub_res = A - B;
  assign accept  = in_valid && in_ready;

  // Single-cycle datapath; any code not handled here (incl. mul/div when absent) yields 0.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_NOR:  alu_res = ~(A | B);
      OP_ADD: begin
        alu_res = add_res;
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_res;
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_res[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  alu_res = A << shamt;
      OP_SRL:  alu_res = A >> shamt;
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      cnt_q, cnt_d;
  // mcand: shifting multiplicand for MUL, divisor in the low half for DIV.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  // mplier: multiplier shifting right for MUL, dividend turning into quotient for DIV.
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_mul, is_div, op_signed, last;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod, prod_fin;
  logic [WIDTH:0]     trial, trial_sub;
  logic               trial_ge;
  logic [WIDTH-1:0]   rem_n, quo_n, rem_fin, quo_fin;

  assign in_ready  = (state_q == S_IDLE);
  assign is_mul    = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_MULTU);
  assign is_div    = (alu_ctrl == OP_DIV)  || (alu_ctrl == OP_DIVU);
  assign op_signed = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
  assign mag_a     = (op_signed && A[WIDTH-1]) ? -A : A;
  assign mag_b     = (op_signed && B[WIDTH-1]) ? -B : B;
  assign last      = (cnt_q == SW'(WIDTH-1));

  assign prod      = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign prod_fin  = qneg_q ? -prod : prod;

  // Restoring step: bring down the next dividend bit, subtract if it fits.
  assign trial     = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign trial_sub = trial - {1'b0, mcand_q[WIDTH-1:0]};
  assign trial_ge  = (trial >= {1'b0, mcand_q[WIDTH-1:0]});
  assign rem_n     = trial_ge ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_n     = {mplier_q[WIDTH-2:0], trial_ge};
  assign quo_fin   = qneg_q ? -quo_n : quo_n;
  assign rem_fin   = rneg_q ? -rem_n : rem_n;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            acc_d    = '0;
            qneg_d   = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          end else if (is_div && (B == '0)) begin
            out_valid_d = 1'b1;
            result_d    = '1;
            zero_d      = 1'b0;
            overflow_d  = 1'b0;
            hi_d        = A;
            lo_d        = '1;
          end else if (is_div) begin
            state_d  = S_DIV;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag_b};
            mplier_d = mag_a;
            acc_d    = '0;
            qneg_d   = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_d   = op_signed && A[WIDTH-1];
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            overflow_d  = alu_ovf;
          end
        end
      end
      S_MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          hi_d        = prod_fin[2*WIDTH-1:WIDTH];
          lo_d        = prod_fin[WIDTH-1:0];
          result_d    = prod_fin[WIDTH-1:0];
          zero_d      = (prod_fin[WIDTH-1:0] == '0);
          overflow_d  = 1'b0;
        end
      end
      S_DIV: begin
        acc_d    = {{WIDTH{1'b0}}, rem_n};
        mplier_d = quo_n;
        cnt_d    = cnt_q + 1'b1;
        if (last) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          out_valid_d = 1'b1;
          hi_d        = rem_fin;
          lo_d        = quo_fin;
          result_d    = quo_fin;
          zero_d      = (quo_fin == '0);
          overflow_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
`else
  assign in_ready = 1'b1;

  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      zero_d      = (alu_res == '0);
      overflow_d  = alu_ovf;
    end
  end

  assign hi = '0;
  assign lo = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter: issued ops push expected results from a behavioural model; a monitor pops on out_valid.
// Mul/div expectations follow whether ALU_MULDIV_EN is defined for the build.
module tb_alu_iter;
`ifdef ALU_MULDIV_EN
  localparam int ITER = 32;
`else
  localparam int ITER = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] hi, lo;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .alu_ctrl(alu_ctrl), .out_valid(out_valid),
    .result(result), .zero(zero), .overflow(overflow), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          cyc = 0;
  int          last_acc = 0;
  int          n_checks = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural meaning of each opcode, computed with plain arithmetic.
  task automatic push_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int acc_edge);
    exp_t        e;
    logic [31:0] r;
    logic        ov;
    int          lat;
`ifdef ALU_MULDIV_EN
    logic signed [63:0] sp;
    logic [63:0]        up;
`endif
    r = '0; ov = 1'b0; lat = 0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0011: r = a ^ b;
      4'b1100: r = ~(a | b);
      4'b0010: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: r = (a < b) ? 32'd1 : 32'd0;
      4'b0100: r = a << b[4:0];
      4'b0101: r = a >> b[4:0];
      4'b1101: r = $signed(a) >>> b[4:0];
`ifdef ALU_MULDIV_EN
      4'b1001: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        m_hi = sp[63:32]; m_lo = sp[31:0]; r = m_lo; lat = ITER;
      end
      4'b1010: begin
        up = {32'b0, a} * {32'b0, b};
        m_hi = up[63:32]; m_lo = up[31:0]; r = m_lo; lat = ITER;
      end
      4'b1011: begin
        if (b == 32'd0) begin
          m_lo = '1; m_hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000; m_hi = '0; lat = ITER;
        end else begin
          m_lo = $signed(a) / $signed(b); m_hi = $signed(a) % $signed(b); lat = ITER;
        end
        r = m_lo;
      end
      4'b1110: begin
        if (b == 32'd0) begin
          m_lo = '1; m_hi = a;
        end else begin
          m_lo = a / b; m_hi = a % b; lat = ITER;
        end
        r = m_lo;
      end
`endif
      default: r = '0;
    endcase
    e.res = r; e.z = (r == 32'd0); e.ov = ov; e.hi = m_hi; e.lo = m_lo;
    e.cyc = acc_edge + lat;
    sb.push_back(e);
  endtask

  // Holds the request until accepted; called and returns at a falling edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int waitc = 0;
    in_valid = 1'b1; alu_ctrl = op; A = a; B = b;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(waitc), 64'd0);
      in_valid = 1'b0;
    end else begin
      last_acc = cyc + 1;
      push_exp(op, a, b, last_acc);
      @(negedge clk);
      in_valid = 1'b0;
      A = $urandom; B = $urandom; alu_ctrl = 4'($urandom);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_result"}, 64'(result), 64'd0);
    check({tag, "_zero"}, 64'(zero), 64'd1);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'd0);
    check({tag, "_lo"}, 64'(lo), 64'd0);
  endtask

  function automatic logic [31:0] rand_opnd();
    logic [31:0] sp [6];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
    if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
    if ($urandom_range(0, 2) == 0) return 32'($urandom_range(0, 40));
    return $urandom;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'(result), 64'(mon_e.res));
        check("zero", 64'(zero), 64'(mon_e.z));
        check("overflow", 64'(overflow), 64'(mon_e.ov));
        check("hi", 64'(hi), 64'(mon_e.hi));
        check("lo", 64'(lo), 64'(mon_e.lo));
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int mul_acc;
    int waitc;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; alu_ctrl = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_vals("reset");

    issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
    issue(4'b0110, 32'd5, 32'd5);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1000, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1101, 32'h8000_0000, 32'd4);
    issue(4'b0100, 32'd3, 32'd33);
    issue(4'b0101, 32'h8000_0000, 32'd31);
    issue(4'b1111, 32'h1234_5678, 32'h1);

    issue(4'b1001, -32'sd3, 32'd7);
    mul_acc = last_acc;
    issue(4'b0010, 32'd10, 32'd20);
    check("held_accept_edge", 64'(last_acc), 64'(mul_acc + ITER + 1));

    issue(4'b1011, -32'sd7, 32'd2);
    issue(4'b1110, 32'd7, 32'd0);
    issue(4'b1011, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'b1011, 32'd7, -32'sd2);
    issue(4'b1110, 32'hFFFF_FFFF, 32'd10);

    issue(4'b1010, 32'h1234_5678, 32'h9ABC_DEF0);
    mul_acc = last_acc;
    while (cyc < mul_acc + 9) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(4'b0010, 32'd100, 32'd23);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(4'($urandom_range(0, 15)), rand_opnd(), rand_opnd());
    end

    waitc = 0;
    while (sb.size() != 0 && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
